// File: rtl/mem_data_ctrl.sv
// Data-memory controller for the load/store unit.
// Single-edge request/response with RV32 sub-word access and fault detection.
module mem_data_ctrl #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_word_q;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      f3_q, f3_d;

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            accept;
  logic            range_f, f3_bad, mis, fault;
  logic            we;
  logic [3:0]      be;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ext;

  assign idx    = req_addr[AW+1:2];
  assign lane   = req_addr[1:0];
  assign accept = (state_q == IDLE) && req_valid;

  assign range_f = |req_addr[XLEN-1:AW+2];
  assign f3_bad  = req_write
                 ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                 : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign mis     = (req_funct3[1:0] == 2'b01 && req_addr[0])
                || (req_funct3[1:0] == 2'b10 && lane != 2'b00);
  assign fault   = range_f || f3_bad || mis;

  // Faults gate the write enable; reset also blocks any write.
  assign we = rst_n && accept && req_write && !fault;

  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    if (accept) rd_word_q <= mem[idx];
  end

  assign sh = rd_word_q >> {lane_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ext = {16'd0, sh[15:0]};
      default: ext = rd_word_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lane_d  = lane;
          f3_d    = req_funct3;
          rdata_d = '0;
          err_d   = fault;
          state_d = (fault || req_write) ? RESP : RD;
        end
      end
      RD: begin
        rdata_d = ext;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      lane_q  <= 2'b00;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Bench for mem_data_ctrl: vector table, scoreboard queue and
// hand-written back-pressure / reset / back-to-back sequences.
module tb_mem_data_ctrl;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_write = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        resp_valid;
  logic        resp_ready = 1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  mem_data_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t vt[$];

  logic [31:0] model [1024];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request at the earliest cycle, push the expectation,
  // then pop and compare once the response appears.
  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic eerr,
                       input string name, output int acc_cyc);
    exp_t e;
    int lat;
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_write = wr; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    e.rdata = erd; e.err = eerr;
    e.lat = (wr || eerr) ? 1 : 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({name, " valid"}, {31'd0, resp_valid}, 32'd1);
    chk({name, " lat"}, lat, e.lat);
    chk({name, " rdata"}, resp_rdata, e.rdata);
    chk({name, " err"}, {31'd0, resp_err}, {31'd0, e.err});
  endtask

  task automatic addv(input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] r, input logic er);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = d;
    v.rdata = r; v.err = er;
    vt.push_back(v);
  endtask

  initial begin
    int ac, pc;
    logic [31:0] held;
    logic [31:0] a, d;
    logic pwr;

    addv(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    addv(0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0);
    addv(1, 3'b000, 32'h11, 32'h5A, 32'h0, 0);
    addv(0, 3'b010, 32'h10, 0, 32'hDEAD5AEF, 0);
    addv(0, 3'b000, 32'h13, 0, 32'hFFFFFFDE, 0);
    addv(0, 3'b100, 32'h13, 0, 32'h000000DE, 0);
    addv(0, 3'b001, 32'h12, 0, 32'hFFFFDEAD, 0);
    addv(0, 3'b101, 32'h10, 0, 32'h00005AEF, 0);
    addv(0, 3'b000, 32'h11, 0, 32'h0000005A, 0);
    addv(0, 3'b010, 32'h12, 0, 32'h0, 1);
    addv(1, 3'b001, 32'h11, 32'h1234, 32'h0, 1);
    addv(0, 3'b010, 32'h10, 0, 32'hDEAD5AEF, 0);
    addv(0, 3'b010, 32'h1000, 0, 32'h0, 1);
    addv(0, 3'b011, 32'h10, 0, 32'h0, 1);
    addv(0, 3'b110, 32'h10, 0, 32'h0, 1);
    addv(1, 3'b100, 32'h10, 32'h0, 32'h0, 1);
    addv(1, 3'b010, 32'h1004, 32'h1, 32'h0, 1);
    addv(0, 3'b010, 32'h10, 0, 32'hDEAD5AEF, 0);
    addv(1, 3'b001, 32'h12, 32'h77778001, 32'h0, 0);
    addv(0, 3'b001, 32'h12, 0, 32'hFFFF8001, 0);
    addv(0, 3'b101, 32'h12, 0, 32'h00008001, 0);
    addv(0, 3'b010, 32'h10, 0, 32'h80015AEF, 0);
    addv(0, 3'b001, 32'h13, 0, 32'h0, 1);

    #12;
    chk("rst valid", {31'd0, resp_valid}, 32'd0);
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    foreach (vt[i])
      issue(vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata,
            vt[i].rdata, vt[i].err, $sformatf("vec%0d", i), ac);

    // Back-pressure: response held, stray requests ignored.
    @(negedge clk);
    resp_ready = 0;
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp valid0", {31'd0, resp_valid}, 32'd1);
    held = resp_rdata;
    chk("bp rdata0", held, 32'h80015AEF);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1; req_write = 1; req_funct3 = 3'b010;
      req_addr = 32'h10; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 0;
      chk($sformatf("bp valid%0d", k), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp rdata%0d", k), resp_rdata, held);
      chk($sformatf("bp err%0d", k), {31'd0, resp_err}, 32'd0);
      chk($sformatf("bp ready%0d", k), {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1;
    @(negedge clk);
    chk("bp idle valid", {31'd0, resp_valid}, 32'd0);
    chk("bp idle ready", {31'd0, req_ready}, 32'd1);
    issue(0, 3'b010, 32'h10, 0, 32'h80015AEF, 0, "bp readback", ac);

    // Reset while in RD.
    issue(1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0, "rst sw", ac);
    @(negedge clk);
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(posedge clk);
    #1 req_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid rst valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mid rst ready", {31'd0, req_ready}, 32'd1);
    chk("mid rst valid2", {31'd0, resp_valid}, 32'd0);
    issue(0, 3'b010, 32'h40, 0, 32'hCAFEF00D, 0, "rst readback", ac);

    // Back-to-back alternating SW/LW.
    pc = ac; pwr = 0;
    for (int k = 0; k < 16; k++) begin
      a = {20'd0, $urandom_range(0, 1023) % 1024 * 4};
      a = {20'd0, a[11:0]};
      d = $urandom;
      model[a[11:2]] = d;
      issue(1, 3'b010, a, d, 0, 0, $sformatf("b2b sw%0d", k), ac);
      chk($sformatf("b2b ivl sw%0d", k), ac - pc, pwr ? 2 : 3);
      pc = ac;
      issue(0, 3'b010, a, 0, model[a[11:2]], 0,
            $sformatf("b2b lw%0d", k), ac);
      chk($sformatf("b2b ivl lw%0d", k), ac - pc, 2);
      pc = ac; pwr = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1);
  end

endmodule
